// File: rtl/bus_pkg.sv
// Shared system-bus definitions: arbiter state encoding, default sizing and master indices.
package bus_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_OWN     = 2'd1,
        ARB_RELEASE = 2'd2
    } arb_state_e;

    localparam int unsigned NUM_MASTERS_DEF   = 3;
    localparam int unsigned OWNER_W_DEF       = 2;
    localparam int unsigned TURNAROUND_CYCLES = 1;

    localparam int unsigned MST_DEMO   = 0;
    localparam int unsigned MST_BRIDGE = 1;
    localparam int unsigned MST_SPARE  = 2;

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-priority encoder: lowest eligible index at or above ptr_i, else wraps to lowest overall.
module rr_pick #(
    parameter int unsigned N = 3,
    parameter int unsigned W = 2
) (
    input  logic [N-1:0] elig_i,
    input  logic [W-1:0] ptr_i,
    output logic [W-1:0] idx_o,
    output logic         valid_o
);

    logic [W-1:0] hi_idx;
    logic [W-1:0] lo_idx;
    logic         hi_vld;

    // Descending scans so the lowest qualifying index is the one left standing.
    always_comb begin
        hi_idx = '0;
        lo_idx = '0;
        hi_vld = 1'b0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (elig_i[i]) begin
                lo_idx = W'(i);
                if (W'(i) >= ptr_i) begin
                    hi_idx = W'(i);
                    hi_vld = 1'b1;
                end
            end
        end
    end

    assign idx_o   = hi_vld ? hi_idx : lo_idx;
    assign valid_o = |elig_i;

endmodule

// File: rtl/bus_rr_arbiter.sv
// Round-robin system-bus arbiter with one-deep slave split parking.
// Define ARB_TIMEOUT_EN to add the forced-release ownership timeout.
module bus_rr_arbiter
    import bus_pkg::*;
#(
    parameter int unsigned NUM_MASTERS    = NUM_MASTERS_DEF,
    parameter int unsigned OWNER_W        = OWNER_W_DEF,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [NUM_MASTERS-1:0] req,
    input  logic                   done,
    input  logic                   split,
    input  logic                   split_rdy,
    output logic [NUM_MASTERS-1:0] grant,
    output logic [OWNER_W-1:0]     owner,
    output logic                   bus_busy,
    output logic                   split_pend,
    output logic                   timeout_err
);

    if (NUM_MASTERS < 2 || NUM_MASTERS > 8 || int'(OWNER_W) < $clog2(NUM_MASTERS)
        || TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65536 || TURNAROUND_CYCLES != 1) begin : g_cfg_chk
        $error("bus_rr_arbiter: unsupported parameter combination");
    end

    arb_state_e             state_q, state_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [OWNER_W-1:0]     owner_q, owner_d;
    logic [OWNER_W-1:0]     ptr_q, ptr_d;
    logic [OWNER_W-1:0]     spl_mst_q, spl_mst_d;
    logic                   busy_q, busy_d;
    logic                   spl_pend_q, spl_pend_d;
    logic                   spl_rdy_q, spl_rdy_d;

    logic [NUM_MASTERS-1:0] parked_c, elig_c;
    logic [OWNER_W-1:0]     pick_idx_c, win_idx_c, nxt_ptr_c;
    logic                   pick_vld_c, resume_c, win_vld_c, tmo_hit_c, release_c;

    assign parked_c  = spl_pend_q ? (NUM_MASTERS'(1) << spl_mst_q) : '0;
    assign elig_c    = req & ~parked_c;
    assign resume_c  = spl_pend_q & spl_rdy_q & req[spl_mst_q];
    assign win_idx_c = resume_c ? spl_mst_q : pick_idx_c;
    assign win_vld_c = resume_c | pick_vld_c;
    assign nxt_ptr_c = (owner_q == OWNER_W'(NUM_MASTERS - 1)) ? '0 : owner_q + OWNER_W'(1);
    assign release_c = done | split | ~req[owner_q] | tmo_hit_c;

    rr_pick #(
        .N (NUM_MASTERS),
        .W (OWNER_W)
    ) u_rr_pick (
        .elig_i  (elig_c),
        .ptr_i   (ptr_q),
        .idx_o   (pick_idx_c),
        .valid_o (pick_vld_c)
    );

`ifdef ARB_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;
    logic        tmo_q, tmo_d;
    assign tmo_hit_c   = (cnt_q == 16'(TIMEOUT_CYCLES - 1));
    assign timeout_err = tmo_q;
`else
    assign tmo_hit_c   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // The turnaround cycle doubles as an arbitration slot, so back-to-back owners see a single dark cycle.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        owner_d    = owner_q;
        busy_d     = busy_q;
        ptr_d      = ptr_q;
        spl_pend_d = spl_pend_q;
        spl_mst_d  = spl_mst_q;
        spl_rdy_d  = spl_rdy_q;
`ifdef ARB_TIMEOUT_EN
        cnt_d      = cnt_q;
        tmo_d      = 1'b0;
`endif
        if (spl_pend_q) begin
            if (!req[spl_mst_q]) begin
                spl_pend_d = 1'b0;
                spl_rdy_d  = 1'b0;
            end else if (split_rdy) begin
                spl_rdy_d = 1'b1;
            end
        end

        case (state_q)
            ARB_IDLE, ARB_RELEASE: begin
                state_d = ARB_IDLE;
                if (win_vld_c) begin
                    state_d = ARB_OWN;
                    grant_d = NUM_MASTERS'(1) << win_idx_c;
                    owner_d = win_idx_c;
                    busy_d  = 1'b1;
`ifdef ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                    if (resume_c) begin
                        spl_pend_d = 1'b0;
                        spl_rdy_d  = 1'b0;
                    end
                end
            end
            ARB_OWN: begin
`ifdef ARB_TIMEOUT_EN
                cnt_d = cnt_q + 16'd1;
`endif
                if (release_c) begin
                    state_d = ARB_RELEASE;
                    grant_d = '0;
                    owner_d = '0;
                    busy_d  = 1'b0;
                    ptr_d   = nxt_ptr_c;
                    // A second split, or split coinciding with done, is just a completion.
                    if (split && !done && !spl_pend_q) begin
                        spl_pend_d = 1'b1;
                        spl_mst_d  = owner_q;
                        spl_rdy_d  = 1'b0;
                    end
`ifdef ARB_TIMEOUT_EN
                    tmo_d = ~done & ~split & req[owner_q];
`endif
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ARB_IDLE;
            grant_q    <= '0;
            owner_q    <= '0;
            ptr_q      <= '0;
            spl_mst_q  <= '0;
            busy_q     <= 1'b0;
            spl_pend_q <= 1'b0;
            spl_rdy_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            owner_q    <= owner_d;
            ptr_q      <= ptr_d;
            spl_mst_q  <= spl_mst_d;
            busy_q     <= busy_d;
            spl_pend_q <= spl_pend_d;
            spl_rdy_q  <= spl_rdy_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
            tmo_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tmo_q <= tmo_d;
        end
    end
`endif

    assign grant      = grant_q;
    assign owner      = owner_q;
    assign bus_busy   = busy_q;
    assign split_pend = spl_pend_q;

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Directed bench for bus_rr_arbiter: vector table plus hand sequences for abort, split and reset corners.
module tb_bus_rr_arbiter;
    import bus_pkg::*;

    localparam int unsigned NM  = 3;
    localparam int unsigned OW  = 2;
    localparam int unsigned TMO = 16;

    logic          clk = 1'b0;
    logic          rstn;
    logic [NM-1:0] req;
    logic          done, split, split_rdy;
    logic [NM-1:0] grant;
    logic [OW-1:0] owner;
    logic          bus_busy, split_pend, timeout_err;

    int checks = 0;
    int errors = 0;

    bus_rr_arbiter #(
        .NUM_MASTERS    (NM),
        .OWNER_W        (OW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .req         (req),
        .done        (done),
        .split       (split),
        .split_rdy   (split_rdy),
        .grant       (grant),
        .owner       (owner),
        .bus_busy    (bus_busy),
        .split_pend  (split_pend),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [2:0] req;
        logic       done;
        logic       split;
        logic       srdy;
        logic [2:0] grant;
        logic [1:0] owner;
        logic       busy;
        logic       pend;
    } vec_t;

    vec_t vecs [23];

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] r, input logic d, input logic s, input logic sr);
        req       = r;
        done      = d;
        split     = s;
        split_rdy = sr;
    endtask

    task automatic expect_out(input string tag, input logic [2:0] g, input logic [1:0] o,
                              input logic b, input logic p);
        chk({tag, " grant"}, 8'(grant), 8'(g));
        chk({tag, " owner"}, 8'(owner), 8'(o));
        chk({tag, " busy"}, 8'(bus_busy), 8'(b));
        chk({tag, " pend"}, 8'(split_pend), 8'(p));
        chk({tag, " tmo"}, 8'(timeout_err), 8'(0));
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        drive(3'b000, 1'b0, 1'b0, 1'b0);
        step();
        rstn = 1'b1;
    endtask

    // Grant exclusivity and busy/grant consistency are checked every cycle out of reset.
    always @(negedge clk) begin
        if (rstn) begin
            checks++;
            if (!$onehot0(grant) || (bus_busy !== (|grant))) begin
                errors++;
                $display("FAIL onehot: grant=%b busy=%b required one-hot-or-zero with busy=|grant", grant, bus_busy);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish before 1ms");
        $fatal(1);
    end

    initial begin
        rstn = 1'b0;
        drive(3'b000, 1'b0, 1'b0, 1'b0);
        step();
        expect_out("reset", 3'b000, 2'd0, 1'b0, 1'b0);
        rstn = 1'b1;

        //             rst   req     dn    sp    srdy  grant   own   busy  pend
        vecs[0]  = '{1'b0, 3'b001, 1'b0, 1'b0, 1'b0, 3'b001, 2'd0, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, 3'b001, 1'b1, 1'b0, 1'b0, 3'b000, 2'd0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 2'd0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 2'd0, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 3'b111, 1'b0, 1'b0, 1'b0, 3'b001, 2'd0, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 3'b111, 1'b1, 1'b0, 1'b0, 3'b000, 2'd0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 3'b111, 1'b0, 1'b0, 1'b0, 3'b010, 2'd1, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 3'b111, 1'b1, 1'b0, 1'b0, 3'b000, 2'd0, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 3'b111, 1'b0, 1'b0, 1'b0, 3'b100, 2'd2, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 3'b111, 1'b1, 1'b0, 1'b0, 3'b000, 2'd0, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 3'b111, 1'b0, 1'b0, 1'b0, 3'b001, 2'd0, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 3'b111, 1'b1, 1'b0, 1'b0, 3'b000, 2'd0, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 3'b010, 1'b0, 1'b0, 1'b0, 3'b010, 2'd1, 1'b1, 1'b0};
        vecs[13] = '{1'b0, 3'b111, 1'b0, 1'b0, 1'b0, 3'b010, 2'd1, 1'b1, 1'b0};
        vecs[14] = '{1'b0, 3'b111, 1'b0, 1'b1, 1'b0, 3'b000, 2'd0, 1'b0, 1'b1};
        vecs[15] = '{1'b0, 3'b111, 1'b0, 1'b0, 1'b0, 3'b100, 2'd2, 1'b1, 1'b1};
        vecs[16] = '{1'b0, 3'b111, 1'b0, 1'b0, 1'b1, 3'b100, 2'd2, 1'b1, 1'b1};
        vecs[17] = '{1'b0, 3'b111, 1'b1, 1'b0, 1'b0, 3'b000, 2'd0, 1'b0, 1'b1};
        vecs[18] = '{1'b0, 3'b111, 1'b0, 1'b0, 1'b0, 3'b010, 2'd1, 1'b1, 1'b0};
        vecs[19] = '{1'b0, 3'b111, 1'b1, 1'b0, 1'b0, 3'b000, 2'd0, 1'b0, 1'b0};
        vecs[20] = '{1'b0, 3'b111, 1'b0, 1'b0, 1'b0, 3'b100, 2'd2, 1'b1, 1'b0};
        vecs[21] = '{1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 3'b000, 2'd0, 1'b0, 1'b0};
        vecs[22] = '{1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 2'd0, 1'b0, 1'b0};

        for (int i = 0; i < 23; i++) begin
            if (vecs[i].rst) do_reset();
            drive(vecs[i].req, vecs[i].done, vecs[i].split, vecs[i].srdy);
            step();
            expect_out($sformatf("v%0d", i), vecs[i].grant, vecs[i].owner, vecs[i].busy, vecs[i].pend);
        end
        drive(3'b000, 1'b0, 1'b0, 1'b0);

        // Owner drops req together with done: one release, next requester one cycle later.
        do_reset();
        drive(3'b011, 1'b0, 1'b0, 1'b0);
        step();
        expect_out("abort own", 3'b001, 2'd0, 1'b1, 1'b0);
        drive(3'b010, 1'b1, 1'b0, 1'b0);
        step();
        expect_out("abort rel", 3'b000, 2'd0, 1'b0, 1'b0);
        drive(3'b010, 1'b0, 1'b0, 1'b0);
        step();
        expect_out("abort next", 3'b010, 2'(MST_BRIDGE), 1'b1, 1'b0);
        drive(3'b000, 1'b0, 1'b0, 1'b0);
        step();
        expect_out("abort drop", 3'b000, 2'd0, 1'b0, 1'b0);

        // split together with done is a plain completion.
        do_reset();
        drive(3'b010, 1'b0, 1'b0, 1'b0);
        step();
        expect_out("spdn own", 3'b010, 2'd1, 1'b1, 1'b0);
        drive(3'b010, 1'b1, 1'b1, 1'b0);
        step();
        expect_out("spdn rel", 3'b000, 2'd0, 1'b0, 1'b0);
        drive(3'b010, 1'b0, 1'b0, 1'b0);
        step();
        expect_out("spdn regrant", 3'b010, 2'd1, 1'b1, 1'b0);

        // Second split while one is parked; then the parked master withdraws.
        do_reset();
        drive(3'b011, 1'b0, 1'b0, 1'b0);
        step();
        expect_out("sp2 own0", 3'b001, 2'd0, 1'b1, 1'b0);
        drive(3'b011, 1'b0, 1'b1, 1'b0);
        step();
        expect_out("sp2 park0", 3'b000, 2'd0, 1'b0, 1'b1);
        drive(3'b011, 1'b0, 1'b0, 1'b0);
        step();
        expect_out("sp2 own1", 3'b010, 2'd1, 1'b1, 1'b1);
        drive(3'b011, 1'b0, 1'b1, 1'b0);
        step();
        expect_out("sp2 second", 3'b000, 2'd0, 1'b0, 1'b1);
        drive(3'b011, 1'b0, 1'b0, 1'b0);
        step();
        expect_out("sp2 skip0", 3'b010, 2'd1, 1'b1, 1'b1);
        drive(3'b010, 1'b0, 1'b0, 1'b0);
        step();
        expect_out("sp2 withdraw", 3'b010, 2'd1, 1'b1, 1'b0);
        drive(3'b010, 1'b0, 1'b0, 1'b1);
        step();
        expect_out("sp2 rdy ign", 3'b010, 2'd1, 1'b1, 1'b0);
        drive(3'b000, 1'b1, 1'b0, 1'b0);
        step();
        drive(3'b000, 1'b0, 1'b0, 1'b0);
        step();

        // Reset mid-ownership clears outputs without a clock edge and restarts the pointer at 0.
        do_reset();
        drive(3'b010, 1'b0, 1'b0, 1'b0);
        step();
        expect_out("rst own", 3'b010, 2'd1, 1'b1, 1'b0);
        drive(3'b010, 1'b1, 1'b0, 1'b0);
        step();
        drive(3'b010, 1'b0, 1'b0, 1'b0);
        step();
        expect_out("rst own again", 3'b010, 2'd1, 1'b1, 1'b0);
        #2;
        rstn = 1'b0;
        #1;
        expect_out("rst async", 3'b000, 2'd0, 1'b0, 1'b0);
        step();
        rstn = 1'b1;
        drive(3'b110, 1'b0, 1'b0, 1'b0);
        step();
        expect_out("rst ptr0", 3'b010, 2'(MST_BRIDGE), 1'b1, 1'b0);
        drive(3'b000, 1'b0, 1'b0, 1'b0);
        step();
        step();

`ifdef ARB_TIMEOUT_EN
        do_reset();
        drive(3'b011, 1'b0, 1'b0, 1'b0);
        step();
        expect_out("tmo own", 3'b001, 2'd0, 1'b1, 1'b0);
        for (int k = 1; k < int'(TMO); k++) begin
            step();
            chk($sformatf("tmo hold%0d grant", k), 8'(grant), 8'(3'b001));
            chk($sformatf("tmo hold%0d err", k), 8'(timeout_err), 8'(0));
        end
        step();
        chk("tmo fire grant", 8'(grant), 8'(3'b000));
        chk("tmo fire err", 8'(timeout_err), 8'(1));
        step();
        chk("tmo next grant", 8'(grant), 8'(3'b010));
        chk("tmo next err", 8'(timeout_err), 8'(0));
`else
        do_reset();
        drive(3'b011, 1'b0, 1'b0, 1'b0);
        step();
        repeat (40) step();
        expect_out("no tmo hold", 3'b001, 2'd0, 1'b1, 1'b0);
`endif
        drive(3'b000, 1'b0, 1'b0, 1'b0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_rr_arbiter.md
Name: bus_rr_arbiter

Overview:
- Round-robin arbiter that shares the system bus between several masters: the local demo master, the UART bus-bridge master, and a spare.
- Grants exclusive bus ownership for one whole transaction at a time.
- Supports slave split: a slave releases the bus mid-transaction and reclaims it later for the same master.
- Sits between the master ports and the bus mux; its owner index drives the mux select.

Parameters:
- NUM_MASTERS, 3, number of requesting masters (2..8).
- OWNER_W, 2, width of the owner index; must be ≥ clog2(NUM_MASTERS).
- TIMEOUT_CYCLES, 4096, maximum cycles in OWN before forced release (used only with the optional feature).

Ports:
- clk  input  1  system clock.
- rstn  input  1  asynchronous active-low reset.
- req  input  NUM_MASTERS  per-master bus request; level, held until granted and done.
- done  input  1  one-cycle pulse from the bus: current transaction finished.
- split  input  1  one-cycle pulse from the addressed slave: split current transaction.
- split_rdy  input  1  one-cycle pulse from the slave: the split transaction can resume.
- grant  output  NUM_MASTERS  one-hot grant; all zero when bus idle.
- owner  output  OWNER_W  index of granted master; 0 when idle.
- bus_busy  output  1  high while any grant is active.
- split_pend  output  1  a split master is parked.
- timeout_err  output  1  one-cycle pulse on forced release (optional feature only).

Behaviour:
- Reset (async, rstn=0):
  - grant=0, owner=0, bus_busy=0, split_pend=0, timeout_err=0.
  - RR pointer=0, state=IDLE, split record cleared.
  - Asserting rstn mid-ownership drops grant immediately.
- States:
  - IDLE: in any cycle with an eligible req, register a winner and go to OWN. grant is asserted the cycle after req is first sampled (1-cycle latency).
  - OWN: grant/owner/bus_busy held stable.
    - done → RELEASE.
    - split → RELEASE, record owner as split master, split_pend=1.
    - Owner's req low → RELEASE (abort).
  - RELEASE: grant=0 for exactly one cycle (bus turnaround). RR pointer = owner+1, wrapping at NUM_MASTERS-1 → 0. Then IDLE.
- Eligibility: req[i]=1 and i is not the parked split master.
- Priority: if split_pend and the split master is ready and its req=1, it wins over all others. Otherwise use round-robin starting at the pointer, searching upward with wrap.
- split_rdy handling:
  - Sets an internal ready flag only when split_pend=1; ignored otherwise.
  - Can arrive in any state. If it coincides with IDLE arbitration, it takes effect in the next cycle's arbitration.
  - split_pend clears when the split master is re-granted.
  - If the split master drops req while parked, split_pend clears and that master becomes a normal requester again.
- Only one split can be outstanding. split while split_pend=1 is treated as done (no second record).
- Simultaneous events in OWN:
  - done and split in the same cycle → treat as done.
  - done and req drop in the same cycle → single release.
- No grant ever overlaps: a one-hot check holds every cycle.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - 16-bit counter clears on entering OWN and increments each OWN cycle.
  - Reaching TIMEOUT_CYCLES-1 without done/split → RELEASE, with timeout_err pulsed for one cycle in the RELEASE cycle.
  - RR pointer advances normally.
- Undefined: no counter; an owner may hold the bus indefinitely; timeout_err tied to 0.

Decomposition:
- Shared package (bus_pkg): arbiter state encoding (IDLE/OWN/RELEASE), NUM_MASTERS default, OWNER_W, the bus turnaround constant (1), and the master index constants (local demo master=0, bridge master=1, spare=2).
- One sub-module: rr_pick, a combinational rotate-priority encoder with inputs (eligible vector, pointer) and outputs (winner index, valid). It is reused by the bridge for its own queue.

Test Plan:
- Single request: req=001 → grant=001 one cycle later, owner=0. done pulse → grant=000 for one cycle, then IDLE with bus_busy=0.
- Contention: req=111 held, done after each grant → grant sequence 001,010,100,001 with a one-cycle gap between each.
- Split: master1 owns and split pulses → split_pend=1, master2 granted next. split_rdy during master2's ownership, then done → master1 granted before master0, and split_pend returns to 0.
- Abort/simultaneous: owner drops req in the same cycle as done → exactly one RELEASE cycle. split+done together → split_pend stays 0.
- Reset mid-transfer: rstn=0 while grant=010 → all outputs 0 asynchronously; after rstn=1 with req=010, grant=010 one cycle later and the pointer starts from 0.
- ARB_TIMEOUT_EN with TIMEOUT_CYCLES=16: owner never pulses done → forced release at cycle 16 of OWN, timeout_err high for 1 cycle, next requester granted.
